// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data_mem port between the pipeline MEM stage (requester 0,
// CPU) and a DMA/loader engine (requester 1, DMA).
//
// Ownership is held in a registered owner (NONE / CPU / DMA). Grants are
// combinational from that owner and the live request, so an owner that keeps
// requesting gets one transfer per cycle. A request seen while the owner is
// NONE costs one bubble cycle before it is granted. On contention the owners
// alternate. A locked DMA burst may keep the port, but only until the CPU has
// waited MAX_WAIT cycles; the burst is then pre-empted for one CPU transfer.
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   rst             synchronous active-low reset; while low every output is 0
//   cpu_req_i       CPU access request (held with we/addr/wdata until granted)
//   cpu_we_i        CPU write enable
//   cpu_addr_i      CPU byte address
//   cpu_wdata_i     CPU write data
//   cpu_gnt_o       CPU access performed this cycle
//   cpu_rdata_o     CPU read data (0 when not granted)
//   cpu_stall_o     cpu_req_i & ~cpu_gnt_o, holds the pipeline MEM stage
//   dma_req_i       DMA access request (held until granted)
//   dma_lock_i      DMA asks to keep ownership for a burst
//   dma_we_i        DMA write enable
//   dma_addr_i      DMA byte address
//   dma_wdata_i     DMA write data
//   dma_gnt_o       DMA access performed this cycle
//   dma_rdata_o     DMA read data (0 when not granted)
//   mem_ce_o        data_mem chip enable
//   mem_we_o        data_mem write enable (write commits at the rising edge)
//   mem_addr_o      data_mem address
//   mem_wdata_o     data_mem write data
//   mem_rdata_i     data_mem combinational read data
//   conflict_cnt_o  saturating count of cycles with both requests high
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic             cpu_gnt_o,
    output logic [31:0]      cpu_rdata_o,
    output logic             cpu_stall_o,
    input  logic             dma_req_i,
    input  logic             dma_lock_i,
    input  logic             dma_we_i,
    input  logic [31:0]      dma_addr_i,
    input  logic [31:0]      dma_wdata_i,
    output logic             dma_gnt_o,
    output logic [31:0]      dma_rdata_o,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic             rr_q, rr_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    logic             cpu_gnt_s;
    logic             dma_gnt_s;
    logic             both_req_s;
    logic             wait_expired_s;

    // Grants follow the registered owner; reset masks them so nothing
    // (in particular no write) reaches data_mem while rst is low.
    assign cpu_gnt_s  = rst & (owner_q == OWN_CPU) & cpu_req_i;
    assign dma_gnt_s  = rst & (owner_q == OWN_DMA) & dma_req_i;
    assign both_req_s = cpu_req_i & dma_req_i;

    // Pre-emption test is done one cycle ahead (wait+1) so the CPU is granted
    // on the cycle after it has waited MAX_WAIT cycles. 9 bits avoid overflow.
    assign wait_expired_s = (({1'b0, wait_q} + 9'd1) >= 9'(MAX_WAIT));

    // State register: owner, tie-break bit, CPU wait counter, conflict counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            rr_q       <= 1'b0;
            wait_q     <= 8'd0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            wait_q     <= wait_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-owner selection. The rr tie-break applies only from NONE; an
    // existing owner is kept or handed over by the contention rules.
    always_comb begin
        owner_d = owner_q;
        if (both_req_s) begin
            case (owner_q)
                OWN_CPU: begin
                    owner_d = OWN_DMA;
                end
                OWN_DMA: begin
                    if (dma_lock_i && !wait_expired_s) begin
                        owner_d = OWN_DMA;
                    end else begin
                        owner_d = OWN_CPU;
                    end
                end
                default: begin
                    owner_d = rr_q ? OWN_DMA : OWN_CPU;
                end
            endcase
        end else if (cpu_req_i) begin
            owner_d = OWN_CPU;
        end else if (dma_req_i) begin
            owner_d = OWN_DMA;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Tie-break bit, CPU wait counter and conflict counter updates.
    always_comb begin
        rr_d       = rr_q;
        wait_d     = 8'd0;
        conflict_d = conflict_q;

        // rr flips whenever contention moves the port to the other side.
        if (both_req_s && (owner_d != owner_q)) begin
            rr_d = ~rr_q;
        end else begin
            rr_d = rr_q;
        end

        if (cpu_req_i && !cpu_gnt_s) begin
            if (wait_q == 8'hFF) begin
                wait_d = 8'hFF;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d = 8'd0;
        end

        if (both_req_s && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end else begin
            conflict_d = conflict_q;
        end
    end

    // Output mux: memory port and read data follow the single active grant.
    always_comb begin
        cpu_gnt_o      = cpu_gnt_s;
        dma_gnt_o      = dma_gnt_s;
        cpu_stall_o    = rst & cpu_req_i & ~cpu_gnt_s;
        mem_ce_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = 32'd0;
        mem_wdata_o    = 32'd0;
        cpu_rdata_o    = 32'd0;
        dma_rdata_o    = 32'd0;
        conflict_cnt_o = '0;

        if (cpu_gnt_s) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            cpu_rdata_o = mem_rdata_i;
        end else if (dma_gnt_s) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
            dma_rdata_o = mem_rdata_i;
        end else begin
            mem_ce_o    = 1'b0;
        end

        if (rst) begin
            conflict_cnt_o = conflict_q;
        end else begin
            conflict_cnt_o = '0;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single data_mem port between the pipeline MEM stage (requester 0, CPU) and a DMA/loader engine (requester 1, DMA).
- Sits between riscv data_*_o/data_i and data_mem ce/we/addr/data_i/data_o inside the SoC top.
- Alternates owners on contention and supports locked DMA bursts.
- Bounds CPU starvation with a wait counter and raises cpu_stall_o so the pipeline holds MEM.

Parameters:
- MAX_WAIT, 8: CPU wait cycles after which a locked DMA burst is pre-empted; legal range 1..255.
- CNT_W, 16: width of the saturating contention counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  CPU write enable
- cpu_addr_i  in  32  CPU byte address
- cpu_wdata_i  in  32  CPU write data
- cpu_gnt_o  out  1  CPU access performed this cycle
- cpu_rdata_o  out  32  CPU read data
- cpu_stall_o  out  1  cpu_req_i & ~cpu_gnt_o
- dma_req_i  in  1  DMA access request
- dma_lock_i  in  1  DMA requests burst ownership
- dma_we_i  in  1  DMA write enable
- dma_addr_i  in  32  DMA byte address
- dma_wdata_i  in  32  DMA write data
- dma_gnt_o  out  1  DMA access performed this cycle
- dma_rdata_o  out  32  DMA read data
- mem_ce_o  out  1  to data_mem ce
- mem_we_o  out  1  to data_mem we
- mem_addr_o  out  32  to data_mem addr
- mem_wdata_o  out  32  to data_mem data_i
- mem_rdata_i  in  32  from data_mem data_o (combinational read)
- conflict_cnt_o  out  CNT_W  cycles with both requests high

Behaviour:
- State register owner ∈ {NONE, CPU, DMA}.
- rr bit: 0 = CPU preferred on tie; toggles each time ownership switches on contention.
- wait_cnt: 8 bits, saturating.
- Reset (rst=0 at an edge): owner=NONE, rr=0, wait_cnt=0, conflict_cnt=0.
  - While rst=0, all outputs are forced to 0: gnts, stall, mem_ce/we/addr/wdata, rdata buses.
  - A reset mid-burst drops ownership; no memory write occurs in any cycle where rst=0.
- Grants are combinational from the registered owner: cpu_gnt_o = (owner==CPU) & cpu_req_i; dma_gnt_o = (owner==DMA) & dma_req_i.
  - A transfer occurs in a cycle with req & gnt.
  - Requesters hold req/we/addr/wdata stable until granted.
- Memory mux:
  - mem_* is driven from the granted requester; with no grant, mem_ce_o=0 and addr/wdata/we=0.
  - Writes commit at that cycle's rising edge (data_mem behaviour).
  - Read data: mem_rdata_i is routed to the granted requester's rdata in the same cycle; the non-granted rdata is 0.
- Latency: a request from owner NONE is granted the next cycle (1 bubble). Back-to-back requests by the current owner get 1 transfer per cycle.
- Next-owner rules, evaluated at each edge:
  - No requests: NONE.
  - Only one request: that requester.
  - Both requesting, owner NONE: CPU if rr=0, else DMA.
  - Owner CPU, both requesting: switch to DMA after the current transfer (CPU never locks).
  - Owner DMA, both requesting, dma_lock_i=0: switch to CPU.
  - Owner DMA, both requesting, dma_lock_i=1: stay DMA, unless wait_cnt+1 ≥ MAX_WAIT, in which case force CPU.
    - dma_gnt_o drops; DMA keeps req asserted and resumes later.
- wait_cnt: increments on cpu_req_i & ~cpu_gnt_o; clears on any CPU grant or when cpu_req_i=0.
- conflict_cnt_o: increments when cpu_req_i & dma_req_i; saturates at all-ones, never wraps.
- The fixed-point owner is preserved when a request drops and rises again in the same cycle as the other requester's first request: the tie rule applies only from NONE.

Test Plan:
1. Reset/idle: hold rst=0 for 3 cycles, then release with no requests → every output 0 and owner NONE; conflict_cnt_o=0.
2. Single requester: CPU write addr 0x10 data 0x5A, then read 0x10.
   - cpu_gnt_o rises 1 cycle after first req.
   - mem_we_o=1 on the write cycle.
   - cpu_rdata_o=0x5A on the read-grant cycle.
   - cpu_stall_o=1 only on the first cycle.
3. Contention, no lock: both req continuously for 10 cycles → grants alternate CPU, DMA, CPU, … starting with CPU (rr=0); conflict_cnt_o=10.
4. Locked burst: DMA lock=1 holding, CPU requests at cycle 0.
   - DMA retains grant until the CPU has waited 8 cycles.
   - cpu_gnt_o asserts on the 9th cycle; DMA re-granted afterwards.
5. Reset mid-burst: rst=0 while owner=DMA with a write pending.
   - No write reaches data_mem.
   - After release, first grant arrives 1 cycle after requests.
6. Saturation: with CNT_W=4, drive 20 contention cycles → conflict_cnt_o holds 15.
